// File: rtl/magia_tile_boot_ctrl.sv
// Per-tile power-up and sleep/wake sequencer driving magia_tile enables, boot address and wu_wfe.
// Optional drain watchdog enabled by defining MAGIA_TILE_BOOT_CTRL_WDT_EN.
module magia_tile_boot_ctrl #(
    parameter int N_WAKE_SRC    = 4,
    parameter int EN_DELAY      = 8,
    parameter int CNT_W         = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  boot_req_i,
    input  logic [31:0]           boot_addr_cfg_i,
    input  logic                  stop_req_i,
    input  logic                  core_sleep_i,
    input  logic [N_WAKE_SRC-1:0] wake_src_i,
    input  logic [N_WAKE_SRC-1:0] wake_mask_i,
    output logic                  tile_enable_o,
    output logic                  fetch_enable_o,
    output logic [31:0]           boot_addr_o,
    output logic                  wu_wfe_o,
    output logic                  busy_o,
    output logic [2:0]            state_o,
    output logic [CNT_W-1:0]      wake_cnt_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENABLE = 3'd1,
        RUN    = 3'd2,
        SLEEP  = 3'd3,
        WAKE   = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    localparam logic [7:0] DLY_INIT = 8'(EN_DELAY - 1);

    state_t           state_reg;
    logic [7:0]       dly_reg;
    logic             pending_reg;
    logic             drain_first_reg;
    logic             tile_enable_reg;
    logic             fetch_enable_reg;
    logic [31:0]      boot_addr_reg;
    logic             wu_wfe_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] wake_cnt_reg;
    logic             done_reg;
    logic             wake_evt;
    logic             wdt_expire;

    assign wake_evt = |(wake_src_i & wake_mask_i);

`ifdef MAGIA_TILE_BOOT_CTRL_WDT_EN
    localparam int WDT_W = $clog2(DRAIN_TIMEOUT + 1);
    logic [WDT_W-1:0] wdt_reg;
    logic             timeout_reg;
    assign wdt_expire = (wdt_reg == WDT_W'(DRAIN_TIMEOUT - 1));
    assign timeout_o  = timeout_reg;
`else
    logic unused_drain_timeout;
    assign unused_drain_timeout = (DRAIN_TIMEOUT > 0);
    assign wdt_expire = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= IDLE;
            dly_reg          <= '0;
            pending_reg      <= 1'b0;
            drain_first_reg  <= 1'b0;
            tile_enable_reg  <= 1'b0;
            fetch_enable_reg <= 1'b0;
            boot_addr_reg    <= '0;
            wu_wfe_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            wake_cnt_reg     <= '0;
            done_reg         <= 1'b0;
`ifdef MAGIA_TILE_BOOT_CTRL_WDT_EN
            wdt_reg          <= '0;
            timeout_reg      <= 1'b0;
`endif
        end else begin
            wu_wfe_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (boot_req_i) begin
                        state_reg       <= ENABLE;
                        tile_enable_reg <= 1'b1;
                        boot_addr_reg   <= boot_addr_cfg_i;
                        dly_reg         <= DLY_INIT;
                        pending_reg     <= 1'b0;
                        busy_reg        <= 1'b1;
`ifdef MAGIA_TILE_BOOT_CTRL_WDT_EN
                        timeout_reg     <= 1'b0;
`endif
                    end
                end
                ENABLE: begin
                    if (stop_req_i) begin
                        state_reg       <= IDLE;
                        tile_enable_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                    end else if (dly_reg == 8'd0) begin
                        state_reg        <= RUN;
                        fetch_enable_reg <= 1'b1;
                    end else begin
                        dly_reg <= dly_reg - 8'd1;
                    end
                end
                RUN, SLEEP: begin
                    if (stop_req_i) begin
                        state_reg       <= DRAIN;
                        pending_reg     <= 1'b0;
                        drain_first_reg <= 1'b1;
`ifdef MAGIA_TILE_BOOT_CTRL_WDT_EN
                        wdt_reg         <= '0;
`endif
                    end else begin
                        pending_reg <= pending_reg | wake_evt;
                        // WAKE is entered on the already-latched bit, so wu_wfe rises together with the state.
                        if (pending_reg && (state_reg == SLEEP || core_sleep_i)) begin
                            state_reg  <= WAKE;
                            wu_wfe_reg <= 1'b1;
                            if (wake_cnt_reg != {CNT_W{1'b1}})
                                wake_cnt_reg <= wake_cnt_reg + 1'b1;
                        end else if (state_reg == RUN && core_sleep_i) begin
                            state_reg <= SLEEP;
                        end
                    end
                end
                WAKE: begin
                    state_reg   <= RUN;
                    pending_reg <= wake_evt;
                end
                DRAIN: begin
                    drain_first_reg  <= 1'b0;
                    fetch_enable_reg <= 1'b0;
                    // Sleep status is ignored in the first cycle: the core has not yet seen fetch drop.
                    if ((!drain_first_reg && core_sleep_i) || wdt_expire) begin
                        state_reg       <= IDLE;
                        tile_enable_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                        done_reg        <= 1'b1;
`ifdef MAGIA_TILE_BOOT_CTRL_WDT_EN
                        if (!(!drain_first_reg && core_sleep_i))
                            timeout_reg <= 1'b1;
                    end else begin
                        wdt_reg <= wdt_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    tile_enable_reg  <= 1'b0;
                    fetch_enable_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                    pending_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign tile_enable_o  = tile_enable_reg;
    assign fetch_enable_o = fetch_enable_reg;
    assign boot_addr_o    = boot_addr_reg;
    assign wu_wfe_o       = wu_wfe_reg;
    assign busy_o         = busy_reg;
    assign state_o        = state_reg;
    assign wake_cnt_o     = wake_cnt_reg;
    assign done_o         = done_reg;

endmodule

// File: tb/tb_magia_tile_boot_ctrl.sv
// Scoreboard bench for magia_tile_boot_ctrl: stimulus queues expected output events,
// a negedge monitor pops one whenever the control outputs change.
module tb_magia_tile_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        boot_req = 1'b0;
    logic [31:0] boot_addr_cfg = '0;
    logic        stop_req = 1'b0;
    logic        core_sleep = 1'b0;
    logic [3:0]  wake_src = '0;
    logic [3:0]  wake_mask = 4'b0010;
    logic        tile_enable, fetch_enable, wu_wfe, busy, done, timeout;
    logic [31:0] boot_addr;
    logic [2:0]  state;
    logic [7:0]  wake_cnt;

    magia_tile_boot_ctrl #(
        .N_WAKE_SRC(4), .EN_DELAY(8), .CNT_W(8), .DRAIN_TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .boot_req_i(boot_req),
        .boot_addr_cfg_i(boot_addr_cfg), .stop_req_i(stop_req),
        .core_sleep_i(core_sleep), .wake_src_i(wake_src), .wake_mask_i(wake_mask),
        .tile_enable_o(tile_enable), .fetch_enable_o(fetch_enable),
        .boot_addr_o(boot_addr), .wu_wfe_o(wu_wfe), .busy_o(busy),
        .state_o(state), .wake_cnt_o(wake_cnt), .done_o(done), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        te, fe, wfe, dn, to;
        logic [7:0]  cnt;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic expect_ev(input int c, input logic [2:0] st, input logic te,
                             input logic fe, input logic wfe, input logic dn,
                             input logic to, input logic [7:0] cnt, input logic [31:0] addr);
        exp_t e;
        e.cyc = c; e.st = st; e.te = te; e.fe = fe; e.wfe = wfe;
        e.dn = dn; e.to = to; e.cnt = cnt; e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any change of state or a control output is one transaction.
    logic [7:0] prev_snap = 8'hFF;
    always @(negedge clk) begin
        logic [7:0] snap;
        exp_t       e;
        snap = {state, tile_enable, fetch_enable, wu_wfe, done, timeout};
        if (snap !== prev_snap) begin
            prev_snap = snap;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d got st=%0d te=%b fe=%b wfe=%b done=%b to=%b",
                         cyc, state, tile_enable, fetch_enable, wu_wfe, done, timeout);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || state !== e.st || tile_enable !== e.te ||
                    fetch_enable !== e.fe || wu_wfe !== e.wfe || done !== e.dn ||
                    timeout !== e.to || wake_cnt !== e.cnt || boot_addr !== e.addr ||
                    busy !== (e.st != 3'd0)) begin
                    bad++;
                    $display("FAIL event got cyc=%0d st=%0d te=%b fe=%b wfe=%b done=%b to=%b busy=%b cnt=%0d addr=%h want cyc=%0d st=%0d te=%b fe=%b wfe=%b done=%b to=%b cnt=%0d addr=%h",
                             cyc, state, tile_enable, fetch_enable, wu_wfe, done, timeout, busy,
                             wake_cnt, boot_addr, e.cyc, e.st, e.te, e.fe, e.wfe, e.dn, e.to,
                             e.cnt, e.addr);
                end else begin
                    $display("ok   event cyc=%0d st=%0d te=%b fe=%b wfe=%b done=%b to=%b cnt=%0d addr=%h",
                             cyc, state, tile_enable, fetch_enable, wu_wfe, done, timeout,
                             wake_cnt, boot_addr);
                end
            end
        end
    end

    initial begin
        // reset state
        expect_ev(1, 3'd0, 0, 0, 0, 0, 0, 8'd0, 32'h0);
        at_cycle(2);  rst_ni = 1'b1;

        // boot: tile_enable at T+1, fetch_enable at T+1+EN_DELAY
        expect_ev(11, 3'd1, 1, 0, 0, 0, 0, 8'd0, 32'hCC00_0080);
        expect_ev(19, 3'd2, 1, 1, 0, 0, 0, 8'd0, 32'hCC00_0080);
        at_cycle(10); boot_req = 1'b1; boot_addr_cfg = 32'hCC00_0080;
        at_cycle(11); boot_req = 1'b0; boot_addr_cfg = 32'h0;

        // sleep, then masked-in wake event
        expect_ev(26, 3'd3, 1, 1, 0, 0, 0, 8'd0, 32'hCC00_0080);
        expect_ev(32, 3'd4, 1, 1, 1, 0, 0, 8'd1, 32'hCC00_0080);
        expect_ev(33, 3'd2, 1, 1, 0, 0, 0, 8'd1, 32'hCC00_0080);
        expect_ev(34, 3'd3, 1, 1, 0, 0, 0, 8'd1, 32'hCC00_0080);
        at_cycle(25); core_sleep = 1'b1;
        at_cycle(30); wake_src = 4'b0010;
        at_cycle(31); wake_src = 4'b0000;
        // masked-out pulse must not wake; next enabled pulse does
        at_cycle(38); wake_mask = 4'b0000; wake_src = 4'b0010;
        at_cycle(39); wake_src = 4'b0000;
        at_cycle(42); core_sleep = 1'b0;
        expect_ev(46, 3'd4, 1, 1, 1, 0, 0, 8'd2, 32'hCC00_0080);
        expect_ev(47, 3'd2, 1, 1, 0, 0, 0, 8'd2, 32'hCC00_0080);
        at_cycle(44); wake_mask = 4'b0010; wake_src = 4'b0010;
        at_cycle(45); wake_src = 4'b0000;

        // race: event in RUN, sleep 3 cycles later -> RUN->WAKE directly, then SLEEP
        expect_ev(54, 3'd4, 1, 1, 1, 0, 0, 8'd3, 32'hCC00_0080);
        expect_ev(55, 3'd2, 1, 1, 0, 0, 0, 8'd3, 32'hCC00_0080);
        expect_ev(56, 3'd3, 1, 1, 0, 0, 0, 8'd3, 32'hCC00_0080);
        at_cycle(50); wake_src = 4'b0010;
        at_cycle(51); wake_src = 4'b0000;
        at_cycle(53); core_sleep = 1'b1;

        // stop in SLEEP with a simultaneous wake event -> drain, no wu_wfe
        expect_ev(61, 3'd5, 1, 1, 0, 0, 0, 8'd3, 32'hCC00_0080);
        expect_ev(62, 3'd5, 1, 0, 0, 0, 0, 8'd3, 32'hCC00_0080);
        expect_ev(63, 3'd0, 0, 0, 0, 1, 0, 8'd3, 32'hCC00_0080);
        expect_ev(64, 3'd0, 0, 0, 0, 0, 0, 8'd3, 32'hCC00_0080);
        at_cycle(60); stop_req = 1'b1; wake_src = 4'b0010;
        at_cycle(61); stop_req = 1'b0; wake_src = 4'b0000;
        at_cycle(66); core_sleep = 1'b0;

        // abort at ENABLE cycle 3
        expect_ev(71, 3'd1, 1, 0, 0, 0, 0, 8'd3, 32'h1234_5678);
        expect_ev(74, 3'd0, 0, 0, 0, 0, 0, 8'd3, 32'h1234_5678);
        at_cycle(70); boot_req = 1'b1; boot_addr_cfg = 32'h1234_5678;
        at_cycle(71); boot_req = 1'b0;
        at_cycle(73); stop_req = 1'b1;
        at_cycle(74); stop_req = 1'b0;

        // boot, then a boot request in RUN is ignored; drain with late sleep
        expect_ev(81, 3'd1, 1, 0, 0, 0, 0, 8'd3, 32'hA000_0000);
        expect_ev(89, 3'd2, 1, 1, 0, 0, 0, 8'd3, 32'hA000_0000);
        expect_ev(101, 3'd5, 1, 1, 0, 0, 0, 8'd3, 32'hA000_0000);
        expect_ev(102, 3'd5, 1, 0, 0, 0, 0, 8'd3, 32'hA000_0000);
        expect_ev(111, 3'd0, 0, 0, 0, 1, 0, 8'd3, 32'hA000_0000);
        expect_ev(112, 3'd0, 0, 0, 0, 0, 0, 8'd3, 32'hA000_0000);
        at_cycle(80); boot_req = 1'b1; boot_addr_cfg = 32'hA000_0000;
        at_cycle(81); boot_req = 1'b0;
        at_cycle(95); boot_req = 1'b1; boot_addr_cfg = 32'hDEAD_BEEF;
        at_cycle(96); boot_req = 1'b0;
        at_cycle(100); stop_req = 1'b1;
        at_cycle(101); stop_req = 1'b0;
        at_cycle(110); core_sleep = 1'b1;
        at_cycle(114); core_sleep = 1'b0;

        // drain with core never sleeping
        expect_ev(121, 3'd1, 1, 0, 0, 0, 0, 8'd3, 32'h0000_0100);
        expect_ev(129, 3'd2, 1, 1, 0, 0, 0, 8'd3, 32'h0000_0100);
        expect_ev(136, 3'd5, 1, 1, 0, 0, 0, 8'd3, 32'h0000_0100);
        expect_ev(137, 3'd5, 1, 0, 0, 0, 0, 8'd3, 32'h0000_0100);
        at_cycle(120); boot_req = 1'b1; boot_addr_cfg = 32'h0000_0100;
        at_cycle(121); boot_req = 1'b0;
        at_cycle(135); stop_req = 1'b1;
        at_cycle(136); stop_req = 1'b0;
`ifdef MAGIA_TILE_BOOT_CTRL_WDT_EN
        // watchdog fires after 16 DRAIN cycles; next boot clears timeout
        expect_ev(152, 3'd0, 0, 0, 0, 1, 1, 8'd3, 32'h0000_0100);
        expect_ev(153, 3'd0, 0, 0, 0, 0, 1, 8'd3, 32'h0000_0100);
        expect_ev(161, 3'd1, 1, 0, 0, 0, 0, 8'd3, 32'h0000_0200);
        expect_ev(166, 3'd0, 0, 0, 0, 0, 0, 8'd3, 32'h0000_0200);
        at_cycle(160); boot_req = 1'b1; boot_addr_cfg = 32'h0000_0200;
        at_cycle(161); boot_req = 1'b0;
        at_cycle(165); stop_req = 1'b1;
        at_cycle(166); stop_req = 1'b0;
`else
        // without watchdog DRAIN waits until sleep finally arrives
        expect_ev(181, 3'd0, 0, 0, 0, 1, 0, 8'd3, 32'h0000_0100);
        expect_ev(182, 3'd0, 0, 0, 0, 0, 0, 8'd3, 32'h0000_0100);
        at_cycle(180); core_sleep = 1'b1;
        at_cycle(185); core_sleep = 1'b0;
`endif

        // asynchronous reset mid-RUN drops enables within the same cycle
        expect_ev(201, 3'd1, 1, 0, 0, 0, 0, 8'd3, 32'h0000_0300);
        expect_ev(209, 3'd2, 1, 1, 0, 0, 0, 8'd3, 32'h0000_0300);
        expect_ev(212, 3'd0, 0, 0, 0, 0, 0, 8'd0, 32'h0);
        at_cycle(200); boot_req = 1'b1; boot_addr_cfg = 32'h0000_0300;
        at_cycle(201); boot_req = 1'b0;
        at_cycle(212); rst_ni = 1'b0;
        at_cycle(214); rst_ni = 1'b1;

        at_cycle(220);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event got none want cyc=%0d st=%0d", e.cyc, e.st);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
